weight_stream_loader: RTL and testbench



---
 rtl/weight_loader_pkg.sv | 20 ++
 rtl/weight_word_packer.sv | 52 +++++
 rtl/weight_stream_loader.sv | 105 ++++++++++
 tb/tb_weight_stream_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_loader_pkg.sv
// Shared types and sizing helpers for the weight stream loader.
// Imported by the packer and the top level.
package weight_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } state_t;

    function automatic int beats_per_word(input int e, input int p);
        return e / p;
    endfunction

    function automatic int addr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/weight_word_packer.sv
// Beat counter and pack buffer: merges P-element beats into one
// E-element word, little-endian by beat then element.
module weight_word_packer
    import weight_loader_pkg::*;
#(
    parameter int W = 16,
    parameter int P = 1,
    parameter int E = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           beat_valid,
    input  logic [P*W-1:0] beat,
    output logic           word_valid,
    output logic [E*W-1:0] word
);

    localparam int BPW = beats_per_word(E, P);
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    logic [BCW-1:0] beat_cnt;
    logic [E*W-1:0] pack_buf;
    logic [E*W-1:0] next_buf;
    logic           last_beat;

    // The word out includes the beat being accepted this cycle.
    always_comb begin
        next_buf = pack_buf;
        for (int j = 0; j < P; j++) begin
            next_buf[(int'(beat_cnt) * P + j) * W +: W] =
                beat[j * W +: W];
        end
    end

    assign last_beat  = (beat_cnt == BCW'(BPW - 1));
    assign word_valid = beat_valid && last_beat;
    assign word       = next_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            pack_buf <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (beat_valid) begin
            pack_buf <= next_buf;
            beat_cnt <= last_beat ? '0 : beat_cnt + BCW'(1);
        end
    end

endmodule

// File: rtl/weight_stream_loader.sv
// Packs a valid/ready weight stream into full words and writes
// them sequentially into a single-port weight RAM.
module weight_stream_loader
    import weight_loader_pkg::*;
#(
    parameter int WEIGHT_PRECISION_0       = 16,
    parameter int WEIGHT_PARALLELISM_DIM_0 = 1,
    parameter int WEIGHT_PARALLELISM_DIM_1 = 1,
    parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 32,
    parameter int DEPTH                    = 576,
    localparam int W = WEIGHT_PRECISION_0,
    localparam int P = WEIGHT_PARALLELISM_DIM_0
                     * WEIGHT_PARALLELISM_DIM_1,
    localparam int E = WEIGHT_TENSOR_SIZE_DIM_0,
    localparam int ADDR_WIDTH = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [P*W-1:0]        data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [ADDR_WIDTH-1:0] address0,
    output logic                  ce0,
    output logic                  we0,
    output logic [E*W-1:0]        d0,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] words_written
);

    state_t                state;
    state_t                next_state;
    logic                  hs;
    logic                  start_ok;
    logic                  word_valid;
    logic [E*W-1:0]        word;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic                  last_word;

    assign hs        = data_in_valid && data_in_ready;
    assign start_ok  = start && (state == IDLE || state == DONE);
    assign last_word = (word_cnt == ADDR_WIDTH'(DEPTH - 1));
    assign ce0       = we0;

    weight_word_packer #(
        .W (W),
        .P (P),
        .E (E)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .beat_valid (hs),
        .beat       (data_in),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (start) next_state = FILL;
            FILL:  if (word_valid && last_word) next_state = DRAIN;
            DRAIN: next_state = DONE;
            DONE:  if (start) next_state = FILL;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        data_in_ready = (state == FILL);
        done          = (state == DONE);
    end

    // RAM port is registered; address0/d0 hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we0           <= 1'b0;
            address0      <= '0;
            d0            <= '0;
            word_cnt      <= '0;
            words_written <= '0;
        end else begin
            we0 <= word_valid;
            if (word_valid) begin
                address0 <= word_cnt;
                d0       <= word;
            end
            if (start_ok)
                word_cnt <= '0;
            else if (word_valid)
                word_cnt <= word_cnt + ADDR_WIDTH'(1);
            if (start_ok)
                words_written <= '0;
            else if (we0)
                words_written <= words_written + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Randomized and directed bench for weight_stream_loader against
// a byte-queue reference model (P=2, E=4, W=8, DEPTH=3).
module tb_weight_stream_loader;

    localparam int W     = 8;
    localparam int P     = 2;
    localparam int E     = 4;
    localparam int DEPTH = 3;
    localparam int AW    = $clog2(DEPTH) + 1;
    localparam int BPW   = E / P;
    localparam int NB    = DEPTH * BPW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [P*W-1:0]  data_in = '0;
    logic            data_in_valid = 1'b0;
    logic            data_in_ready;
    logic [AW-1:0]   address0;
    logic            ce0;
    logic            we0;
    logic [E*W-1:0]  d0;
    logic            done;
    logic [AW-1:0]   words_written;

    weight_stream_loader #(
        .WEIGHT_PRECISION_0       (W),
        .WEIGHT_PARALLELISM_DIM_0 (2),
        .WEIGHT_PARALLELISM_DIM_1 (1),
        .WEIGHT_TENSOR_SIZE_DIM_0 (E),
        .DEPTH                    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .address0      (address0),
        .ce0           (ce0),
        .we0           (we0),
        .d0            (d0),
        .done          (done),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    bit          m_loading;
    int          m_n;
    bit          m_done;
    int          m_ww;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_d;
    logic [7:0]  q[$];
    int          log_addr[$];
    logic [31:0] log_data[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 0;
        m_n       = 0;
        m_done    = 0;
        m_ww      = 0;
        m_we      = 0;
        m_addr    = 0;
        m_d       = '0;
        q.delete();
    endtask

    task automatic check_outputs();
        chk("ready", 64'(data_in_ready),
            64'(m_loading && m_n < NB));
        chk("we0", 64'(we0), 64'(m_we));
        chk("ce0", 64'(ce0), 64'(m_we));
        chk("addr0", 64'(address0), 64'(m_addr));
        chk("d0", 64'(d0), 64'(m_d));
        chk("done", 64'(done), 64'(m_done));
        chk("words_written", 64'(words_written), 64'(m_ww));
        if (m_we) begin
            log_addr.push_back(m_addr);
            log_data.push_back(m_d);
        end
    endtask

    // One clock: drive inputs, advance model, check after the edge.
    task automatic step(input bit v, input bit s,
                        input logic [15:0] d);
        bit hs;
        bit n_we;
        bit n_loading;
        bit n_done;
        int n_n;
        int n_ww;
        data_in       = d;
        data_in_valid = v;
        start         = s;
        hs        = m_loading && m_n < NB && v;
        n_we      = 0;
        n_loading = m_loading;
        n_done    = m_done;
        n_n       = m_n;
        n_ww      = m_ww + (m_we ? 1 : 0);
        if (hs) begin
            q.push_back(d[7:0]);
            q.push_back(d[15:8]);
            n_n++;
            if (n_n % BPW == 0) begin
                n_we   = 1;
                m_addr = n_n / BPW - 1;
                for (int i = 0; i < E; i++) m_d[i*8 +: 8] = q[i];
                q.delete();
            end
        end
        if (m_loading && m_n == NB) begin
            n_loading = 0;
            n_done    = 1;
        end
        if (s && !m_loading) begin
            n_loading = 1;
            n_n       = 0;
            n_done    = 0;
            n_ww      = 0;
            q.delete();
        end
        m_loading = n_loading;
        m_n       = n_n;
        m_done    = n_done;
        m_ww      = n_ww;
        m_we      = n_we;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        step(1'b1, 1'b0, {b, a});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst           = 1'b0;
        start         = 1'b0;
        data_in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_words[3];
        exp_words[0] = 32'h04030201;
        exp_words[1] = 32'h08070605;
        exp_words[2] = 32'h0C0B0A09;

        // 1: reset, then idle with valid held high
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 16'($urandom));

        // 2: back-to-back load
        log_addr.delete();
        log_data.delete();
        step(1'b0, 1'b1, 16'h0);
        for (int b = 0; b < NB; b++)
            beat(8'(2*b + 1), 8'(2*b + 2));
        idle(3);
        chk("s2_nwrites", 64'(log_addr.size()), 64'd3);
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            chk("s2_addr", 64'(log_addr[i]), 64'(i));
            chk("s2_data", 64'(log_data[i]), 64'(exp_words[i]));
        end
        chk("s2_ww", 64'(words_written), 64'd3);

        // 3: valid toggling
        step(1'b0, 1'b1, 16'h0);
        for (int b = 0; b < NB; b++) begin
            beat(8'(2*b + 1), 8'(2*b + 2));
            step(1'b0, 1'b0, 16'hFFFF);
        end
        idle(3);

        // 4: start mid-load is ignored
        step(1'b0, 1'b1, 16'h0);
        for (int b = 0; b < 3; b++) beat(8'(b), 8'(b + 16));
        step(1'b1, 1'b1, 16'h3333);
        for (int b = 4; b < NB; b++) beat(8'(b), 8'(b + 16));
        idle(3);

        // 5: reset mid-load, then full load of 0xAA
        step(1'b0, 1'b1, 16'h0);
        for (int b = 0; b < 3; b++) beat(8'h55, 8'h66);
        do_reset();
        log_addr.delete();
        log_data.delete();
        step(1'b0, 1'b1, 16'h0);
        for (int b = 0; b < NB; b++) beat(8'hAA, 8'hAA);
        idle(3);
        chk("s5_nwrites", 64'(log_addr.size()), 64'd3);
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            chk("s5_addr", 64'(log_addr[i]), 64'(i));
            chk("s5_data", 64'(log_data[i]), 64'hAAAAAAAA);
        end

        // 6: beats offered in DONE, then reload
        for (int i = 0; i < 4; i++) beat(8'h11, 8'h22);
        step(1'b0, 1'b1, 16'h0);
        chk("s6_done_drop", 64'(done), 64'd0);
        chk("s6_ww_clear", 64'(words_written), 64'd0);
        for (int b = 0; b < NB; b++) beat(8'(b + 64), 8'(b + 96));
        idle(3);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7,
                     $urandom_range(0, 14) == 0,
                     16'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
